// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encoding, opcodes, ALU op codes and control word for the MIPS multicycle core
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_outputs.sv
// rtl/main_fsm_outputs.sv - combinational state to control-word decode (Moore outputs)
module main_fsm_outputs
  import mips_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = 1'b1;
      end
      DECODE: ctrl.alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.branch    = 1'b1;
      end
      JEX: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_fsm.sv
// rtl/mips_main_fsm.sv - multicycle MIPS main control FSM: state register, next-state logic, pc_en gate
module mips_main_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [1:0] aluop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_en,
  output logic [3:0] state_o
);

  state_t state, state_next, dec_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      state_next = MEMRD;
        else if (op == OP_SW) state_next = MEMWR;
        else                  state_next = FETCH;
      end
      MEMRD:   state_next = MEMWB;
      RTYPEEX: state_next = RTYPEWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  // While reset is high the decode sees FETCH (defined selects, even before the
  // register is initialised) and every write enable is masked off.
  always_comb begin
    dec_state  = reset ? FETCH : state;
    aluop      = ctrl.aluop;
    alu_src_a  = ctrl.alu_src_a;
    alu_src_b  = ctrl.alu_src_b;
    pc_src     = ctrl.pc_src;
    iord       = ctrl.iord;
    reg_dst    = ctrl.reg_dst;
    mem_to_reg = ctrl.mem_to_reg;
    ir_write   = ctrl.ir_write & ~reset;
    mem_write  = ctrl.mem_write & ~reset;
    reg_write  = ctrl.reg_write & ~reset;
    pc_en      = (ctrl.pc_write | (ctrl.branch & zero)) & ~reset;
    state_o    = state;
  end

  main_fsm_outputs u_outputs (
    .state (dec_state),
    .ctrl  (ctrl)
  );

endmodule

// File: tb/tb_mips_main_fsm.sv
// tb/tb_mips_main_fsm.sv - randomized self-checking bench for mips_main_fsm against an instruction-level model
module tb_mips_main_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic [1:0] aluop;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       pc_en;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  mips_main_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .aluop      (aluop),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .iord       (iord),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .pc_en      (pc_en),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] obs_ctrl;
  assign obs_ctrl = {aluop, alu_src_a, alu_src_b, pc_src, iord, reg_dst, mem_to_reg,
                     ir_write, mem_write, reg_write};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected control word for one cycle of an instruction, as listed in the control table.
  function automatic logic [12:0] exp_ctrl(input int s);
    logic [1:0] a_op = 2'b00, srcb = 2'b00, pcs = 2'b00;
    logic       srca = 0, io = 0, rd = 0, m2r = 0, irw = 0, mw = 0, rw = 0;
    case (s)
      0:  begin irw = 1; srcb = 2'b01; end
      1:  srcb = 2'b11;
      2, 9: begin srca = 1; srcb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin srca = 1; a_op = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin srca = 1; a_op = 2'b01; pcs = 2'b01; end
      10: rw = 1;
      11: pcs = 2'b10;
      default: ;
    endcase
    return {a_op, srca, srcb, pcs, io, rd, m2r, irw, mw, rw};
  endfunction

  function automatic bit is_known(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
           o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
  endfunction

  // Runs one instruction from FETCH; zsel < 0 randomizes zero every cycle.
  task automatic run_instr(input logic [5:0] o, input int zsel);
    int seq[$];
    bit z;
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = '{0, 1};
    endcase
    op = o;
    foreach (seq[k]) begin
      z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      zero = z;
      #1;
      check($sformatf("state op=%b k=%0d", o, k), 16'(state_o), 16'(seq[k]));
      check($sformatf("ctrl op=%b st=%0d", o, seq[k]), 16'(obs_ctrl), 16'(exp_ctrl(seq[k])));
      check($sformatf("pc_en op=%b st=%0d z=%0d", o, seq[k], z), 16'(pc_en),
            16'((seq[k] == 0) || (seq[k] == 11) || (seq[k] == 8 && z)));
      @(posedge clk);
      #1;
    end
    #1;
    check($sformatf("latency op=%b", o), 16'(state_o), 16'd0);
  endtask

  logic [12:0] reset_ctrl;
  logic [5:0]  rop;
  logic [5:0]  op_table [6];

  initial begin
    op_table   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    reset_ctrl = 13'b00_0_01_00_000000;
    reset = 1'b1;
    op    = 6'b100011;
    zero  = 1'b1;
    #2;
    check("reset ctrl before edge", 16'(obs_ctrl), 16'(reset_ctrl));
    check("reset pc_en before edge", 16'(pc_en), 16'd0);
    @(posedge clk);
    #1;
    check("reset ctrl cycle 2", 16'(obs_ctrl), 16'(reset_ctrl));
    check("reset pc_en cycle 2", 16'(pc_en), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(6'b100011, -1);
    run_instr(6'b000000, -1);
    run_instr(6'b000100, 1);
    run_instr(6'b000100, 0);
    run_instr(6'b000010, -1);
    run_instr(6'b111111, -1);
    run_instr(6'b101011, -1);
    run_instr(6'b001000, -1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 6) == 6) begin
        do rop = 6'($urandom); while (is_known(rop));
      end else begin
        rop = op_table[$urandom_range(0, 5)];
      end
      run_instr(rop, -1);
    end

    // Abort a store in MEMWR with reset.
    op   = 6'b101011;
    zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sw reaches MEMWR", 16'(state_o), 16'd5);
    check("sw mem_write in MEMWR", 16'(mem_write), 16'd1);
    reset = 1'b1;
    #1;
    check("abort ctrl under reset", 16'(obs_ctrl), 16'(reset_ctrl));
    check("abort pc_en under reset", 16'(pc_en), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("state after abort", 16'(state_o), 16'd0);
    run_instr(6'b000000, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_main_fsm.md
# mips_main_fsm

Multicycle main control FSM for the MIPS core; the stage directly upstream of `alu_decoder`. Each cycle it decodes the current state and the latched instruction opcode into datapath enables, mux selects and the 2-bit `aluop` consumed by `alu_decoder`. Moore machine: all outputs are a pure function of state, except `pc_en`, which also uses `zero`.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode, instr[31:26], from the instruction register.
- `zero` in 1: ALU zero flag.
- `aluop` out 2: to `alu_decoder`. 00 = add, 01 = sub, 10 = funct-decoded.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- `pc_src` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = memory data, 0 = ALUOut.
- `ir_write`, `mem_write`, `reg_write` out 1 each: write enables.
- `pc_en` out 1: PC update. Equals `pc_write | (branch & zero)`.
- `state_o` out 4: current state, for debug and bench.

## Operation
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Transitions:
  - FETCH→DECODE.
  - DECODE by `op`: lw/sw→MEMADR, R→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX, any other opcode→FETCH (executes as nop).
  - MEMADR: lw→MEMRD, sw→MEMWR.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX→FETCH.
- Output defaults: all 1-bit outputs 0; `aluop`/`alu_src_b`/`pc_src` 00. Per-state overrides below.
  - FETCH: `ir_write`=1, `alu_src_b`=01, internal `pc_write`=1.
  - DECODE: `alu_src_b`=11.
  - MEMADR, ADDIEX: `alu_src_a`=1, `alu_src_b`=10.
  - MEMRD: `iord`=1.
  - MEMWR: `iord`=1, `mem_write`=1.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1.
  - RTYPEEX: `alu_src_a`=1, `aluop`=10.
  - RTYPEWB: `reg_write`=1, `reg_dst`=1.
  - ADDIWB: `reg_write`=1.
  - BEQEX: `alu_src_a`=1, `aluop`=01, `pc_src`=01, internal `branch`=1.
  - JEX: `pc_src`=10, internal `pc_write`=1.
- `aluop`=11 is never driven.

## Timing
- State register updates on rising `clk`. Outputs are valid combinationally within the same cycle as the state.
- Reset cycle:
  - Next state = FETCH.
  - `ir_write`, `mem_write`, `reg_write` and `pc_en` are forced 0 while `reset`=1.
  - All other outputs take their FETCH values: `alu_src_b`=01, rest 0.
  - `state_o`=0 in the first cycle after reset deasserts.
- Reset mid-instruction aborts the instruction. The state returns to FETCH on the next edge, and no write enable asserts during the reset cycle.
- Instruction latency in cycles, FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- `op` is sampled only in DECODE and MEMADR. It is assumed stable there because `ir_write`=0 outside FETCH.
- `pc_en` is combinational. In BEQEX it follows `zero` within the same cycle.

## Structure
- `mips_pkg`:
  - `state_t` enum, 4-bit, values as listed above.
  - Opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALUOP_ADD/SUB/FUNCT constants, shared with `alu_decoder`.
- Sub-module `main_fsm_outputs`: combinational state→control-word decode. The top level holds the state register, next-state logic and the `pc_en` gate.

## Test plan
- Reset held 2 cycles, then released:
  - During reset: all write enables 0, `alu_src_b`=01.
  - After release: `state_o` sequence 0,1.
- lw (`op`=100011):
  - States 0,1,2,3,4,0.
  - MEMRD has `iord`=1.
  - MEMWB has `reg_write`=1 and `mem_to_reg`=1.
- R-type (`op`=000000):
  - RTYPEEX has `aluop`=10 and `alu_src_a`=1.
  - RTYPEWB has `reg_write`=1 and `reg_dst`=1.
  - 4 cycles total.
- beq:
  - With `zero`=1: BEQEX has `pc_en`=1 and `pc_src`=01.
  - With `zero`=0: `pc_en`=0.
  - 3 cycles in both cases.
- j, and unknown opcode 111111:
  - j: JEX has `pc_en`=1 and `pc_src`=10.
  - Unknown: DECODE→FETCH with no writes asserted.
- Reset asserted in MEMWR (sw):
  - `mem_write` drops to 0 in the same cycle.
  - `state_o`=0 after the edge.
